// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment scanner:
// digit count, digit index type, active-high glyph constants and the leading-zero helper.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_idx_t;

    // Glyphs are active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bit i set when digit i and every digit above it are zero; digit 0 is never blanked
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] bcd,
                                                       input logic en);
        logic                  run;
        logic [NUM_DIGITS-1:0] mask;
        run  = en;
        mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run     = run && (bcd[4*i +: 4] == 4'd0);
            mask[i] = run;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD code to active-high 7-segment glyph; codes 10-15 show nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'd0: glyph = SEG_0;
            4'd1: glyph = SEG_1;
            4'd2: glyph = SEG_2;
            4'd3: glyph = SEG_3;
            4'd4: glyph = SEG_4;
            4'd5: glyph = SEG_5;
            4'd6: glyph = SEG_6;
            4'd7: glyph = SEG_7;
            4'd8: glyph = SEG_8;
            4'd9: glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_8digits.sv
// Eight-digit multiplexed 7-segment driver with frame-atomic updates,
// anti-ghost blanking at each slot start and optional leading-zero suppression.
module seg7_scan_8digits
    import seg7_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYC      = 16,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bcd_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [7:0]  an_out,
    output logic        frame_done
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic [31:0]      act_bcd;
    logic [7:0]       act_dp;
    logic [31:0]      pend_bcd;
    logic [7:0]       pend_dp;
    logic             pend_valid;

    logic             tick;
    logic             boundary;
    logic [3:0]       code;
    logic [6:0]       glyph;
    logic [7:0]       lz;
    logic             blanked;
    logic [6:0]       seg_hi;
    logic             dp_hi;
    logic [7:0]       an_hi;

    assign tick     = (cnt == CNT_W'(DIV - 1));
    assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

    assign code    = act_bcd[{idx, 2'b00} +: 4];
    assign lz      = lz_mask(act_bcd, blank_lz);
    assign blanked = lz[idx];

    seg7_decode u_decode (
        .code  (code),
        .glyph (glyph)
    );

    always_comb begin
        seg_hi = blanked ? SEG_BLANK : glyph;
        dp_hi  = act_dp[idx] && !blanked;
        an_hi  = (cnt < CNT_W'(BLANK_CYC)) ? 8'h00 : (8'b1 << idx);
    end

    // A load landing on the boundary goes straight to active; otherwise it waits in pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            act_bcd    <= '0;
            act_dp     <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            seg_out    <= {7{ACTIVE_LOW_SEG}};
            dp_out     <= ACTIVE_LOW_SEG;
            an_out     <= {8{ACTIVE_LOW_AN}};
            frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= idx + digit_idx_t'(1);
            end
            if (load && !boundary) begin
                pend_bcd   <= bcd_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
            if (boundary) begin
                if (load) begin
                    act_bcd <= bcd_in;
                    act_dp  <= dp_in;
                end else if (pend_valid) begin
                    act_bcd <= pend_bcd;
                    act_dp  <= pend_dp;
                end
                pend_valid <= 1'b0;
            end
            seg_out    <= seg_hi ^ {7{ACTIVE_LOW_SEG}};
            dp_out     <= dp_hi ^ ACTIVE_LOW_SEG;
            an_out     <= an_hi ^ {8{ACTIVE_LOW_AN}};
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_8digits.sv
// Self-checking bench for seg7_scan_8digits with DIV=10, BLANK_CYC=2 and active-low pins.
module tb_seg7_scan_8digits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bcd_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_done;

    int assertions = 0;
    int failures   = 0;
    int edge_cnt   = 0;

    seg7_scan_8digits #(
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .BLANK_CYC      (2),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Independent cycle model: after edge k the scanner sits at cnt=k%10, idx=(k/10)%8
    always @(posedge clk) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  dp;
        logic        lz;
        int          d;
        int          c;
        logic [6:0]  seg;
        logic        dpo;
        logic [7:0]  an;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        assertions++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic do_load(input logic [31:0] b, input logic [7:0] d);
        @(negedge clk);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) timeout(name);
    endtask

    // Lands one step after the edge where the scanner enters slot cycle c of digit d
    task automatic goto_slot(input int d, input int c);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!((edge_cnt % 10 == c) && ((edge_cnt / 10) % 8 == d)) && n < 200);
        if (n >= 200) timeout($sformatf("goto d%0d c%0d", d, c));
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NV; i++) begin
            if (i == 0 || vecs[i].bcd != vecs[i-1].bcd || vecs[i].dp != vecs[i-1].dp) begin
                blank_lz = vecs[i].lz;
                do_load(vecs[i].bcd, vecs[i].dp);
                wait_frame($sformatf("vec%0d frame", i));
            end
            blank_lz = vecs[i].lz;
            goto_slot(vecs[i].d, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpo, vecs[i].an);
        end
    endtask

    task automatic checkOutput(input string name, input logic [6:0] seg, input logic dpo,
                               input logic [7:0] an);
        check({name, " seg"}, {1'b0, seg_out}, {1'b0, seg});
        check({name, " dp"},  {7'b0, dp_out},  {7'b0, dpo});
        check({name, " an"},  an_out, an);
    endtask

    initial begin
        int n;

        vecs[0]  = '{32'h12345678, 8'h10, 1'b0, 0, 3, 7'h00, 1'b1, 8'hFE};
        vecs[1]  = '{32'h12345678, 8'h10, 1'b0, 0, 2, 7'h00, 1'b1, 8'hFF};
        vecs[2]  = '{32'h12345678, 8'h10, 1'b0, 4, 5, 7'h19, 1'b0, 8'hEF};
        vecs[3]  = '{32'h12345678, 8'h10, 1'b0, 7, 9, 7'h79, 1'b1, 8'h7F};
        vecs[4]  = '{32'h12345678, 8'h10, 1'b0, 6, 5, 7'h24, 1'b1, 8'hBF};
        vecs[5]  = '{32'h12345678, 8'h10, 1'b0, 2, 5, 7'h02, 1'b1, 8'hFB};
        vecs[6]  = '{32'h00000705, 8'h80, 1'b1, 7, 5, 7'h7F, 1'b1, 8'h7F};
        vecs[7]  = '{32'h00000705, 8'h80, 1'b1, 3, 5, 7'h7F, 1'b1, 8'hF7};
        vecs[8]  = '{32'h00000705, 8'h80, 1'b1, 2, 5, 7'h78, 1'b1, 8'hFB};
        vecs[9]  = '{32'h00000705, 8'h80, 1'b1, 1, 5, 7'h40, 1'b1, 8'hFD};
        vecs[10] = '{32'h00000705, 8'h80, 1'b1, 0, 5, 7'h12, 1'b1, 8'hFE};
        vecs[11] = '{32'h00000705, 8'h80, 1'b0, 7, 5, 7'h40, 1'b0, 8'h7F};
        vecs[12] = '{32'h00000705, 8'h80, 1'b0, 3, 5, 7'h40, 1'b1, 8'hF7};
        vecs[13] = '{32'h0000000A, 8'h00, 1'b1, 0, 5, 7'h7F, 1'b1, 8'hFE};
        vecs[14] = '{32'h0000000A, 8'h00, 1'b1, 1, 5, 7'h7F, 1'b1, 8'hFD};
        vecs[15] = '{32'h00000000, 8'h00, 1'b1, 0, 5, 7'h40, 1'b1, 8'hFE};
        vecs[16] = '{32'h00000000, 8'h00, 1'b1, 5, 5, 7'h7F, 1'b1, 8'hDF};
        vecs[17] = '{32'h90000000, 8'h01, 1'b1, 6, 5, 7'h40, 1'b1, 8'hBF};
        vecs[18] = '{32'h90000000, 8'h01, 1'b1, 7, 5, 7'h10, 1'b1, 8'h7F};
        vecs[19] = '{32'h90000000, 8'h01, 1'b1, 0, 5, 7'h40, 1'b0, 8'hFE};

        rst_n    = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 7'h7F, 1'b1, 8'hFF);
        check("reset frame_done", {7'b0, frame_done}, 8'h00);

        // First frame_done shows 80 edges after release, i.e. in the 81st cycle with rst_n high
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 200);
        check("first frame_done latency", 8'(n), 8'd80);
        @(posedge clk);
        #1;
        check("frame_done width", {7'b0, frame_done}, 8'h00);

        applyStimulus();

        // Two loads in one frame: only the later one is ever shown
        blank_lz = 1'b0;
        wait_frame("latest-wins sync");
        do_load(32'h11111111, 8'h00);
        do_load(32'h22222222, 8'h00);
        wait_frame("latest-wins frame");
        goto_slot(0, 5);
        check("latest-wins d0", {1'b0, seg_out}, 8'h24);
        goto_slot(7, 5);
        check("latest-wins d7", {1'b0, seg_out}, 8'h24);

        // Load coinciding with the boundary appears in the frame starting there
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (edge_cnt % 80 != 79 && n < 200);
        if (edge_cnt % 80 != 79) timeout("boundary sync");
        @(negedge clk);
        bcd_in = 32'h33333333;
        dp_in  = 8'h00;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        goto_slot(0, 5);
        check("coincident d0", {1'b0, seg_out}, 8'h30);
        goto_slot(7, 5);
        check("coincident d7", {1'b0, seg_out}, 8'h30);

        // Mid-frame reset with a load pending: pending is discarded
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        goto_slot(5, 2);
        do_load(32'h99999999, 8'hFF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid reset", 7'h7F, 1'b1, 8'hFF);
        check("mid reset frame_done", {7'b0, frame_done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        goto_slot(0, 5);
        checkOutput("post reset d0", 7'h40, 1'b1, 8'hFE);
        wait_frame("post reset frame");
        goto_slot(0, 5);
        check("post reset next d0", {1'b0, seg_out}, 8'h40);
        goto_slot(6, 5);
        checkOutput("post reset next d6", 7'h40, 1'b1, 8'hBF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_8digits.md
SEG7_SCAN_8DIGITS -- requirements
Module: seg7_scan_8digits

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, digit-slot rate in Hz; DIV = CLK_HZ/SCAN_HZ SHALL be at least BLANK_CYC+2.
REQ-003 SHALL have parameter BLANK_CYC, default 16, anti-ghost cycles with all anodes off at the start of each slot.
REQ-004 SHALL have parameter ACTIVE_LOW_SEG, default 1, segment and decimal-point polarity.
REQ-005 SHALL have parameter ACTIVE_LOW_AN, default 1, anode polarity.
REQ-006 SHALL have port clk, input, 1, sole clock; the block has one clock, and every flop updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port bcd_in, input, 32, eight packed BCD digits; digit 7 (most significant) is at [31:28] and digit 0 is at [3:0].
REQ-009 SHALL have port dp_in, input, 8, decimal-point mask; bit i lights the decimal point of digit i.
REQ-010 SHALL have port load, input, 1, single-cycle update strobe.
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable, applied live.
REQ-012 SHALL have port seg_out, output, 7, segments {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp_out, output, 1, decimal-point segment.
REQ-014 SHALL have port an_out, output, 8, one-hot digit anodes.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-016 SHALL run prescaler cnt from 0 to DIV-1 and wrap; tick is asserted when cnt==DIV-1.
REQ-017 SHALL advance digit index idx on tick, 0->1->...->7->0; a frame boundary is a tick with idx==7.
REQ-018 SHALL capture {bcd_in, dp_in} into the pending register whenever load=1; a later load overwrites the pending value (latest wins).
REQ-019 SHALL copy pending to the active register at the frame boundary only if pending is valid, then clear the valid flag; the display never shows a mixed frame.
REQ-020 SHALL write {bcd_in, dp_in} directly to active when load coincides with a frame boundary; pending is then left invalid.
REQ-021 SHALL decode codes 0-9 to the standard 7-segment glyphs; codes 10-15 SHALL display blank.
REQ-022 SHALL blank digit i (segments and dp off, anode still driven) when blank_lz=1, active digit i==0, and all higher active digits are 0; digit 0 is never blanked.
REQ-023 SHALL hold all anodes off while cnt<BLANK_CYC; otherwise only anode idx is on.
REQ-024 SHALL register seg_out, dp_out and an_out, so pins lag cnt/idx/active by exactly one cycle.
REQ-025 SHALL pulse frame_done (registered) in the cycle after a frame boundary.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear cnt, idx, active, pending and the pending-valid flag.
REQ-027 SHALL, at the same edge, drive an_out all off (8'hFF with default polarity), seg_out all off (7'h7F), dp_out off (1) and frame_done=0.
REQ-028 SHALL, on a mid-frame reset, discard any pending load and restart at idx=0, cnt=0 on the first cycle with rst_n=1.

Structure
REQ-029 SHALL place the glyph constants (0-9), SEG_BLANK, NUM_DIGITS=8 and the digit index type in the shared package seg7_pkg.
REQ-030 SHALL instantiate one combinational sub-module seg7_decode (4-bit code to active-high 7-bit glyph); polarity is applied in seg7_scan_8digits.

Verification (CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, BLANK_CYC=2, default polarities)
REQ-031 SHALL check: rst_n=0 for 3 cycles -> an_out=8'hFF, seg_out=7'h7F, dp_out=1, frame_done=0; after release, frame_done first pulses 81 cycles later.
REQ-032 SHALL check: load with bcd_in=32'h12345678 and dp_in=8'h10, then wait for the boundary -> digit-0 slot shows seg_out=7'h00 (glyph '8') and an_out=8'hFE from slot cycle 3; digit 4 shows dp_out=0.
REQ-033 SHALL check: bcd_in=32'h00000705 with blank_lz=1 -> digits 7..3 show seg_out=7'h7F; digits 2,1,0 show '7','0','5'; with blank_lz=0 the upper digits show '0'.
REQ-034 SHALL check: loads of 32'h11111111 then 32'h22222222 in the same frame -> the next frame shows only '2'; a load coincident with the boundary is shown in the frame that starts there.
REQ-035 SHALL check: bcd_in=32'h0000000A -> digit 0 is blank; bcd_in=0 with blank_lz=1 -> only digit 0 shows '0' (seg_out=7'h40).
REQ-036 SHALL check: rst_n pulsed low while idx=5 with a load pending -> outputs are off the next cycle; active stays 0, and the pending value is never displayed.
